ipml_stream_pack_wr: RTL and testbench

- Write-side front end for the prefetch line FIFOs (fifo_ping/fifo_pong); the mirror of the read-side prefetch stage.
- Accepts a narrow valid/ready pixel stream, packs RATIO beats little-endian into one FIFO word, and drives the FIFO write port (wr_data/wr_en) against its wr_vld (not-full) flag.
- End-of-line (s_last) or flush forces out a partially filled word, padded.
- Single output holding register; upstream is stalled only while that register is blocked by a full FIFO.

---
 rtl/ipml_stream_pack_wr.sv | 110 +++++++++++
 tb/tb_ipml_stream_pack_wr.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ipml_stream_pack_wr.sv
// Write-side packer for the prefetch line FIFOs: gathers c_RATIO narrow beats
// (first beat in the LSBs) into one FIFO word behind a single output register.
module ipml_stream_pack_wr #(
  parameter int                    c_IN_WIDTH  = 16,
  parameter int                    c_RATIO     = 2,
  parameter logic [c_IN_WIDTH-1:0] c_PAD_VALUE = '0,
  parameter int                    c_CNT_WIDTH = 16
) (
  input  logic                            wr_clk,
  input  logic                            wr_rst,
  input  logic [c_IN_WIDTH-1:0]           s_data,
  input  logic                            s_valid,
  input  logic                            s_last,
  output logic                            s_ready,
  input  logic                            flush,
  output logic [c_IN_WIDTH*c_RATIO-1:0]   fifo_wr_data,
  output logic                            fifo_wr_en,
  input  logic                            fifo_wr_vld,
  output logic                            busy,
  output logic [c_CNT_WIDTH-1:0]          word_cnt
);

  localparam int c_OUT_WIDTH = c_IN_WIDTH * c_RATIO;
  localparam int c_LANE_W    = (c_RATIO > 1) ? $clog2(c_RATIO) : 1;
  localparam logic [c_LANE_W-1:0] c_LAST_LANE = c_LANE_W'(c_RATIO - 1);

  logic [c_LANE_W-1:0]    lane_q, lane_d;
  logic [c_OUT_WIDTH-1:0] acc_q, acc_d;
  logic [c_OUT_WIDTH-1:0] out_q, out_d;
  logic                   out_vld_q, out_vld_d;
  logic                   flush_pend_q, flush_pend_d;
  logic [c_CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic [c_OUT_WIDTH-1:0] merged;
  logic blocked, acc, wacc, flush_req, flush_eff, complete, flush_only, load;

  // Handshakes: a beat moves when s_valid & s_ready; a FIFO write happens when
  // fifo_wr_en & fifo_wr_vld. The only stall is a full output register that the
  // FIFO is refusing this cycle.
  assign blocked    = out_vld_q & ~fifo_wr_vld;
  assign s_ready    = ~wr_rst & ~blocked;
  assign acc        = s_valid & s_ready;
  assign fifo_wr_en = out_vld_q & ~wr_rst;
  assign wacc       = fifo_wr_en & fifo_wr_vld;

  // A flush raised while blocked waits in flush_pend_q for the register to free.
  assign flush_req  = flush | flush_pend_q;
  assign flush_eff  = flush_req & ~blocked;
  assign complete   = acc & ((lane_q == c_LAST_LANE) | s_last | flush_eff);
  assign flush_only = flush_eff & ~acc & (lane_q != '0);
  assign load       = complete | flush_only;

  assign fifo_wr_data = wr_rst ? '0 : out_q;
  assign busy         = ~wr_rst & ((lane_q != '0) | out_vld_q);
  assign word_cnt     = wr_rst ? '0 : cnt_q;

  // Lanes below the current one come from the accumulator, the current lane
  // takes the incoming beat (if any), everything above is padding.
  always_comb begin
    merged = '0;
    for (int k = 0; k < c_RATIO; k++) begin
      if (k < int'(lane_q))
        merged[k*c_IN_WIDTH +: c_IN_WIDTH] = acc_q[k*c_IN_WIDTH +: c_IN_WIDTH];
      else if ((k == int'(lane_q)) && acc)
        merged[k*c_IN_WIDTH +: c_IN_WIDTH] = s_data;
      else
        merged[k*c_IN_WIDTH +: c_IN_WIDTH] = c_PAD_VALUE;
    end
  end

  always_comb begin
    lane_d       = lane_q;
    acc_d        = acc_q;
    out_d        = out_q;
    out_vld_d    = out_vld_q;
    cnt_d        = cnt_q;
    flush_pend_d = flush_req & blocked;
    if (wacc) begin
      out_vld_d = 1'b0;
      cnt_d     = cnt_q + c_CNT_WIDTH'(1);
    end
    if (load) begin
      out_d     = merged;
      out_vld_d = 1'b1;
      lane_d    = '0;
    end else if (acc) begin
      acc_d  = merged;
      lane_d = lane_q + c_LANE_W'(1);
    end
  end

  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      lane_q       <= '0;
      acc_q        <= '0;
      out_q        <= '0;
      out_vld_q    <= 1'b0;
      flush_pend_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      lane_q       <= lane_d;
      acc_q        <= acc_d;
      out_q        <= out_d;
      out_vld_q    <= out_vld_d;
      flush_pend_q <= flush_pend_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ipml_stream_pack_wr.sv
// Bench for ipml_stream_pack_wr: 4 beats per word, 0xDEAD padding, 4-bit word
// counter; expected FIFO words come from a beat-list model, checked by a monitor.
module tb_ipml_stream_pack_wr;

  localparam int W  = 16;
  localparam int R  = 4;
  localparam int OW = W * R;
  localparam int CW = 4;
  localparam logic [W-1:0] PAD = 16'hDEAD;

  logic          wr_clk;
  logic          wr_rst;
  logic [W-1:0]  s_data;
  logic          s_valid;
  logic          s_last;
  logic          s_ready;
  logic          flush;
  logic [OW-1:0] fifo_wr_data;
  logic          fifo_wr_en;
  logic          fifo_wr_vld;
  logic          busy;
  logic [CW-1:0] word_cnt;

  ipml_stream_pack_wr #(
    .c_IN_WIDTH (W),
    .c_RATIO    (R),
    .c_PAD_VALUE(PAD),
    .c_CNT_WIDTH(CW)
  ) dut (
    .wr_clk      (wr_clk),
    .wr_rst      (wr_rst),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_last      (s_last),
    .s_ready     (s_ready),
    .flush       (flush),
    .fifo_wr_data(fifo_wr_data),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_wr_vld (fifo_wr_vld),
    .busy        (busy),
    .word_cnt    (word_cnt)
  );

  // ---------------- clock ----------------
  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  // ---------------- scoreboard / model ----------------
  int            n_cmp = 0;
  int            n_err = 0;
  logic [OW-1:0] exp_q[$];
  logic [W-1:0]  m_beats[$];
  int            m_words = 0;
  bit            m_pend_flush = 0;
  bit            vld_rand = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // A word is the collected beats in arrival order, low lane first, padded up.
  function automatic void model_close();
    logic [OW-1:0] w;
    w = '0;
    for (int k = 0; k < R; k++)
      w[k*W +: W] = (k < m_beats.size()) ? m_beats[k] : PAD;
    exp_q.push_back(w);
    m_words++;
    m_beats.delete();
  endfunction

  function automatic void model_beat(input logic [W-1:0] d, input bit close);
    m_beats.push_back(d);
    if (close || m_pend_flush || m_beats.size() == R) model_close();
    m_pend_flush = 0;
  endfunction

  function automatic void model_flush();
    if (m_beats.size() > 0) model_close();
  endfunction

  // ---------------- monitor ----------------
  bit            prev_stall = 0;
  logic [OW-1:0] prev_data = '0;
  logic [OW-1:0] mon_exp;

  always @(negedge wr_clk) begin
    if (wr_rst) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check("hold_en", 64'(fifo_wr_en), 64'(1));
        check("hold_data", fifo_wr_data, prev_data);
      end
      check("s_ready_rule", 64'(s_ready), 64'(!(fifo_wr_en && !fifo_wr_vld)));
      if (fifo_wr_en && fifo_wr_vld) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_write: got %h expected no write", fifo_wr_data);
        end else begin
          mon_exp = exp_q.pop_front();
          check("wr_data", fifo_wr_data, mon_exp);
        end
      end
      prev_stall = fifo_wr_en && !fifo_wr_vld;
      prev_data  = fifo_wr_data;
    end
  end

  always @(posedge wr_clk) begin
    #1;
    if (vld_rand) fifo_wr_vld = ($urandom_range(0, 3) != 0);
  end

  // ---------------- driver tasks (entered and left at posedge+1) ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge wr_clk);
    #1;
  endtask

  task automatic send_beat(input logic [W-1:0] d, input bit last, input bit fl);
    int n;
    n       = 0;
    s_data  = d;
    s_last  = last;
    flush   = fl;
    s_valid = 1'b1;
    @(negedge wr_clk);
    while (!s_ready && n < 300) begin
      @(negedge wr_clk);
      n++;
    end
    @(posedge wr_clk);
    #1;
    if (n >= 300) begin
      n_cmp++;
      n_err++;
      $display("FAIL beat_timeout: s_ready 0 for %0d cycles, expected 1", n);
    end else begin
      model_beat(d, last | fl);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    flush   = 1'b0;
    s_data  = W'($urandom);
  endtask

  task automatic flush_only();
    int n;
    n     = 0;
    flush = 1'b1;
    @(negedge wr_clk);
    while (!s_ready && n < 300) begin
      @(negedge wr_clk);
      n++;
    end
    @(posedge wr_clk);
    #1;
    flush = 1'b0;
    if (n >= 300) begin
      n_cmp++;
      n_err++;
      $display("FAIL flush_timeout: register blocked %0d cycles, expected free", n);
    end else begin
      model_flush();
    end
  endtask

  task automatic do_reset();
    wr_rst  = 1'b1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    flush   = 1'b0;
    exp_q.delete();
    m_beats.delete();
    m_words      = 0;
    m_pend_flush = 0;
    @(negedge wr_clk);
    check("rst_s_ready", 64'(s_ready), 64'(0));
    check("rst_wr_en", 64'(fifo_wr_en), 64'(0));
    check("rst_wr_data", fifo_wr_data, 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_word_cnt", 64'(word_cnt), 64'(0));
    @(posedge wr_clk);
    #1;
    wr_rst = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(posedge wr_clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: %0d words still expected, required 0", exp_q.size());
    end
    idle(2);
  endtask

  task automatic check_cnt(input string name);
    @(negedge wr_clk);
    check(name, 64'(word_cnt), 64'(m_words % (1 << CW)));
    @(posedge wr_clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    s_valid     = 1'b0;
    s_last      = 1'b0;
    flush       = 1'b0;
    s_data      = '0;
    fifo_wr_vld = 1'b1;
    wr_rst      = 1'b1;
    do_reset();

    // Two full words, no backpressure; first write one cycle after the 4th beat.
    for (int i = 0; i < 8; i++) begin
      send_beat(W'(16'h1111 * (i + 1)), 1'b0, 1'b0);
      if (i == 3) begin
        @(negedge wr_clk);
        check("latency_en", 64'(fifo_wr_en), 64'(1));
        @(posedge wr_clk);
        #1;
      end
    end
    wait_drain();
    check_cnt("cnt_two_words");

    // Short line closed by s_last, padded with 0xDEAD.
    send_beat(16'hA0A0, 1'b0, 1'b0);
    @(negedge wr_clk);
    check("busy_partial", 64'(busy), 64'(1));
    @(posedge wr_clk);
    #1;
    send_beat(16'hB1B1, 1'b1, 1'b0);
    wait_drain();
    @(negedge wr_clk);
    check("busy_idle", 64'(busy), 64'(0));
    @(posedge wr_clk);
    #1;

    // FIFO full for a while with a word pending; release while a beat waits.
    fifo_wr_vld = 1'b0;
    for (int i = 0; i < 4; i++) send_beat(W'(16'h5000 + i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge wr_clk);
      check("stall_en", 64'(fifo_wr_en), 64'(1));
      check("stall_ready", 64'(s_ready), 64'(0));
    end
    @(posedge wr_clk);
    #1;
    fork
      for (int i = 4; i < 8; i++) send_beat(W'(16'h5000 + i), 1'b0, 1'b0);
      begin
        idle(2);
        fifo_wr_vld = 1'b1;
        @(negedge wr_clk);
        check("release_ready", 64'(s_ready), 64'(1));
      end
    join
    wait_drain();

    // Flush pulsed while blocked closes the beat accepted when the register frees.
    fifo_wr_vld = 1'b0;
    for (int i = 0; i < 4; i++) send_beat(W'(16'h6000 + i), 1'b0, 1'b0);
    flush = 1'b1;
    idle(1);
    flush        = 1'b0;
    m_pend_flush = 1;
    fork
      send_beat(16'hC0C0, 1'b0, 1'b0);
      begin
        idle(3);
        fifo_wr_vld = 1'b1;
      end
    join
    send_beat(16'hC1C1, 1'b0, 1'b0);
    send_beat(16'hC2C2, 1'b0, 1'b0);
    flush_only();
    wait_drain();

    // Flush of a one-beat word, then a flush with nothing pending.
    send_beat(16'h00FF, 1'b0, 1'b0);
    flush_only();
    wait_drain();
    flush_only();
    idle(3);
    check_cnt("cnt_empty_flush");

    // Flush coincident with a beat acts as s_last.
    send_beat(16'h1234, 1'b0, 1'b0);
    send_beat(16'h5678, 1'b0, 1'b1);
    wait_drain();
    check_cnt("cnt_coincident_flush");

    // Reset mid-word and mid-stall drops pending data.
    send_beat(16'hAAAA, 1'b0, 1'b0);
    do_reset();
    fifo_wr_vld = 1'b0;
    for (int i = 0; i < 4; i++) send_beat(W'(16'h7000 + i), 1'b0, 1'b0);
    idle(2);
    do_reset();
    fifo_wr_vld = 1'b1;
    idle(3);
    @(negedge wr_clk);
    check("post_rst_en", 64'(fifo_wr_en), 64'(0));
    check("post_rst_cnt", 64'(word_cnt), 64'(0));
    @(posedge wr_clk);
    #1;
    for (int i = 0; i < 4; i++) send_beat(W'(16'h8000 + i), 1'b0, 1'b0);
    wait_drain();
    check_cnt("cnt_clean_word");

    // Random beats, lines, flushes and backpressure.
    vld_rand = 1;
    for (int i = 0; i < 300; i++) begin
      int r;
      r = $urandom_range(0, 11);
      if (r == 0) flush_only();
      else if (r == 1) idle(1);
      else send_beat(W'($urandom), r == 2, r == 3);
    end
    vld_rand = 0;
    idle(1);
    fifo_wr_vld = 1'b1;
    flush_only();
    wait_drain();
    check_cnt("cnt_random");
    @(negedge wr_clk);
    check("busy_after_random", 64'(busy), 64'(0));
    @(posedge wr_clk);
    #1;

    // 17 writes wrap a 4-bit counter to 1.
    do_reset();
    for (int i = 0; i < 17 * R; i++) send_beat(W'($urandom), 1'b0, 1'b0);
    wait_drain();
    @(negedge wr_clk);
    check("cnt_wrap", 64'(word_cnt), 64'(1));

    check("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
